keypad_hex_entry: RTL
=====================

Name: keypad_hex_entry

Overview:
- Scans a 4x4 matrix keypad by driving one active-low column at a time and reading the row lines; debounces and decodes each press into a hex digit.
- Holds a 4-digit (16-bit) entry buffer; each accepted digit shifts in at the right.
- Writes the buffer to the 4-digit display through the display's byte-load interface (data, load0, load1), acting as the writer for that interface.

Parameters:
- SCAN_DIV_BITS, 15, scan tick period is 2^SCAN_DIV_BITS clk50M cycles.
- DEBOUNCE_SCANS, 4, consecutive matching ticks required to accept a press or a release (1..15).

Ports:
- clk50M  in  1  system clock; display load interface must be clocked by the same clock.
- rst  in  1  asynchronous, active-high reset.
- filas  in  4  keypad rows, active-low (external pull-ups), asynchronous.
- columnas  out  4  keypad column drive, active-low one-hot.
- data  out  8  byte to display; low nibble is the lower digit.
- load0  out  1  one-cycle strobe: data = {tens, units}.
- load1  out  1  one-cycle strobe: data = {thousands, hundreds}.
- key_valid  out  1  one-cycle pulse on each accepted key.
- key_code  out  4  code of the last accepted key.

Behaviour:
- Reset values:
  - columnas = 4'b1110; data = 0; load0 = load1 = key_valid = 0; key_code = 0.
  - buffer = 16'h0000; divisor = 0; state = SCAN; synchronizer flops = 4'b1111.
  - No display write is issued on reset.
- filas passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Tick: a free-running divisor generates a one-cycle tick when it wraps.
- Key map (row r = filas bit, col c = active columnas bit):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Valid hit: exactly one synchronized row low. Zero rows low, or two or more rows low, counts as no key.
- FSM, evaluated only on tick unless noted:
  - SCAN: on a valid hit, latch (col, row), clear count, go to DEBOUNCE, and freeze columnas. Otherwise rotate columnas left (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - DEBOUNCE: same row pattern as latched increments count; any other pattern returns to SCAN with rotation resuming on that tick.
    - When count reaches DEBOUNCE_SCANS: set key_code, pulse key_valid, buffer <= {buffer[11:0], code}, start WRITE, go to HELD.
  - HELD: columnas stays frozen; count consecutive ticks with all rows high. Any low row resets the count. At DEBOUNCE_SCANS, go to SCAN. No auto-repeat.
- WRITE sequencer, independent of ticks:
  - Cycle after key_valid: load0 = 1, data = buffer[7:0].
  - Next cycle: load1 = 1, data = buffer[15:8].
  - Then data returns to 0.
  - load0 and load1 are never asserted together. Exactly one load0/load1 pair per accepted key.
- Simultaneous events: a tick during WRITE is processed normally. A new accept cannot occur during WRITE because DEBOUNCE_SCANS >= 1 tick and the tick period is much longer than 2 cycles.
- Reset mid-operation: an asynchronous reset during DEBOUNCE, HELD or WRITE aborts immediately. A partial write (load0 without load1) is permitted, and the buffer is cleared.
- Buffer wrap: the fifth digit shifts the oldest digit out of buffer[15:12]; there is no overflow flag.

Optional Feature:
- KEYPAD_CLEAR_EN defined: key E (r3, c0) does not shift in. It sets buffer = 16'h0000, pulses key_valid with key_code = 4'hE, and issues a write pair of 8'h00, 8'h00.
- Undefined: E behaves as an ordinary digit 0xE.

Test Plan:
- Bench parameters: SCAN_DIV_BITS=2, DEBOUNCE_SCANS=2, tick every 4 cycles.
- Reset, no keys: columnas cycles 1110, 1101, 1011, 0111, 1110 with one step per tick. No load0/load1. key_valid stays 0.
- Hold r1 low while col1 is active (key 5) for 3+ ticks: columnas freezes at 1101. key_valid pulses with key_code = 5. The next cycles give load0 with data = 8'h05, then load1 with data = 8'h00.
- Press and release 1, 2, 3, 4 then A: writes end at {34, 12}, then after A give load0 data = 8'h4A and load1 data = 8'h23 (wrap).
- Bounce: r0 low for 1 tick, high, low 1 tick: no key_valid, and rotation resumes. A hold of r3 + r1 low in the same column gives no key.
- Held key for 20 ticks: exactly one key_valid. After release, a new press of the same key is accepted again.
- Assert rst between load0 and load1: load1 never occurs, all outputs are at reset values, and columnas = 1110.
- KEYPAD_CLEAR_EN: buffer 16'h1234, press E: load0 data = 00, load1 data = 00. Without the macro: load0 data = 8'h4E, load1 data = 8'h23.

Source files
------------

// File: rtl/keypad_hex_entry.sv
// 4x4 keypad scanner with debounce, 4-digit hex entry buffer and display byte-load writer.
// Define KEYPAD_CLEAR_EN to make key E clear the buffer instead of shifting in 0xE.
module keypad_hex_entry #(
  parameter int unsigned SCAN_DIV_BITS  = 15,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk50M,
  input  logic       rst,
  input  logic [3:0] filas,
  output logic [3:0] columnas,
  output logic [7:0] data,
  output logic       load0,
  output logic       load1,
  output logic       key_valid,
  output logic [3:0] key_code
);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

  localparam logic [SCAN_DIV_BITS-1:0] DivOne    = SCAN_DIV_BITS'(1);
  localparam logic [3:0]               DebTarget = 4'(DEBOUNCE_SCANS);

  state_e                   state_q;
  logic [SCAN_DIV_BITS-1:0] div_q;
  logic [3:0]               sync1_q, sync2_q;
  logic [3:0]               row_lat_q;
  logic [3:0]               count_q;
  logic [15:0]              buffer_q;

  logic       tick;
  logic       one_low;
  logic [1:0] row_idx;
  logic [1:0] col_idx;
  logic [3:0] code;
  logic [3:0] count_inc;
  logic [3:0] col_rot;

  assign tick      = &div_q;
  assign count_inc = count_q + 4'd1;
  assign col_rot   = {columnas[2:0], columnas[3]};

  // Exactly one synchronized row low is a hit; anything else is treated as no key.
  always_comb begin
    one_low = 1'b0;
    row_idx = 2'd0;
    case (sync2_q)
      4'b1110: begin one_low = 1'b1; row_idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; row_idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; row_idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; row_idx = 2'd3; end
      default: ;
    endcase
    col_idx = 2'd0;
    case (columnas)
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      4'b0111: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
    case ({row_idx, col_idx})
      4'b0000: code = 4'h1;
      4'b0001: code = 4'h2;
      4'b0010: code = 4'h3;
      4'b0011: code = 4'hA;
      4'b0100: code = 4'h4;
      4'b0101: code = 4'h5;
      4'b0110: code = 4'h6;
      4'b0111: code = 4'hB;
      4'b1000: code = 4'h7;
      4'b1001: code = 4'h8;
      4'b1010: code = 4'h9;
      4'b1011: code = 4'hC;
      4'b1100: code = 4'hE;
      4'b1101: code = 4'h0;
      4'b1110: code = 4'hF;
      default: code = 4'hD;
    endcase
  end

  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state_q   <= StScan;
      div_q     <= '0;
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      row_lat_q <= 4'b1111;
      count_q   <= 4'd0;
      buffer_q  <= 16'h0000;
      columnas  <= 4'b1110;
      data      <= 8'h00;
      load0     <= 1'b0;
      load1     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      div_q     <= div_q + DivOne;
      sync1_q   <= filas;
      sync2_q   <= sync1_q;
      key_valid <= 1'b0;
      // Write pair follows key_valid: low byte, then high byte, then idle.
      load0     <= key_valid;
      load1     <= load0;
      if (key_valid)  data <= buffer_q[7:0];
      else if (load0) data <= buffer_q[15:8];
      else            data <= 8'h00;

      if (tick) begin
        case (state_q)
          StScan: begin
            if (one_low) begin
              row_lat_q <= sync2_q;
              count_q   <= 4'd0;
              state_q   <= StDebounce;
            end else begin
              columnas <= col_rot;
            end
          end
          StDebounce: begin
            if (sync2_q == row_lat_q) begin
              if (count_inc == DebTarget) begin
                key_code  <= code;
                key_valid <= 1'b1;
`ifdef KEYPAD_CLEAR_EN
                if (code == 4'hE) buffer_q <= 16'h0000;
                else              buffer_q <= {buffer_q[11:0], code};
`else
                buffer_q <= {buffer_q[11:0], code};
`endif
                count_q   <= 4'd0;
                state_q   <= StHeld;
              end else begin
                count_q <= count_inc;
              end
            end else begin
              state_q  <= StScan;
              columnas <= col_rot;
            end
          end
          StHeld: begin
            if (sync2_q == 4'b1111) begin
              if (count_inc == DebTarget) state_q <= StScan;
              else                        count_q <= count_inc;
            end else begin
              count_q <= 4'd0;
            end
          end
          default: state_q <= StScan;
        endcase
      end
    end
  end

endmodule
